// File: rtl/shift_sequencer_if.sv
`timescale 1ns/1ps
// shift_sequencer_if: control and req/fin handshake bundle between sequencer and shift register.
// Latency: none, wires only.
// Backpressure: fin signals from the register pace each operation; start is ignored while busy.
interface shift_sequencer_if #(
   parameter int SHW = 6
);
   logic           start;
   logic [SHW-1:0] shiftAmt;
   logic           busy;
   logic           done;
   logic           err;
   logic           saveReq;
   logic           saveFin;
   logic           rightReq;
   logic           rightFin;

   // Sequencer side.
   modport master (
      input  start, shiftAmt, saveFin, rightFin,
      output busy, done, err, saveReq, rightReq
   );

   // Caller and shift-register side.
   modport slave (
      output start, shiftAmt, saveFin, rightFin,
      input  busy, done, err, saveReq, rightReq
   );
endinterface

// File: rtl/shift_sequencer.sv
`timescale 1ns/1ps
// shift_sequencer: issues one save then N right-shift requests to an async req/fin shift register.
// Latency: start seen in cycle t0 -> done in cycle t0+1+(N+1)*(2*HOLD+1) when fin returns promptly.
// Backpressure: each op holds req until synced fin; start is ignored while busy.
// Optional feature macro SHIFT_SEQ_TIMEOUT_EN: bounds each WAIT by TIMEOUT cycles, adds sticky err.
module shift_sequencer #(
   parameter int Width   = 32,
   parameter int SHW     = 6,
   parameter int HOLD    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   shift_sequencer_if.master ifc
);
   localparam int             HCW       = $clog2(HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
   localparam logic [SHW-1:0] WIDTH_MAX = SHW'(Width);

   // Elaboration-time parameter sanity checks.
   if (HOLD < 4) begin : g_hold_chk
      $error("shift_sequencer: HOLD must be at least 4");
   end
   if ((2 ** SHW) <= Width) begin : g_shw_chk
      $error("shift_sequencer: SHW too narrow to hold Width");
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("shift_sequencer: TIMEOUT must be at least 1");
   end

   // S_ERR is only reachable when the timeout feature is built in.
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_LOW, S_DONE, S_ERR} state_t;
   typedef enum logic {OP_SAVE, OP_SHIFT} op_t;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic [SHW-1:0] rem_q, rem_d, rem_dec, amt_clamped;
   logic [HCW-1:0] cnt_q, cnt_d;
   logic [1:0]     save_sync_q, right_sync_q;
   logic           fin_sync;
   logic           timed_out;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           save_req_q, save_req_d;
   logic           right_req_q, right_req_d;

`ifdef SHIFT_SEQ_TIMEOUT_EN
   localparam int             TOW     = $clog2(TIMEOUT + 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
   logic [TOW-1:0] to_cnt_q, to_cnt_d;
   logic           err_q, err_d;

   assign timed_out = (state_q == S_WAIT) && (to_cnt_q == TO_LAST);
   assign ifc.err   = err_q;
`else
   assign timed_out = 1'b0;
   assign ifc.err   = 1'b0;
`endif

   // Requests larger than the register width would only shift in zeros; stop at Width.
   assign amt_clamped = (ifc.shiftAmt > WIDTH_MAX) ? WIDTH_MAX : ifc.shiftAmt;
   // Remaining-shift count after the op that just finished (save ops do not consume one).
   assign rem_dec     = (op_q == OP_SHIFT) ? (rem_q - SHW'(1)) : rem_q;
   // Completion is judged on the fin belonging to the op in flight.
   assign fin_sync    = (op_q == OP_SAVE) ? save_sync_q[1] : right_sync_q[1];

   assign ifc.busy     = busy_q;
   assign ifc.done     = done_q;
   assign ifc.saveReq  = save_req_q;
   assign ifc.rightReq = right_req_q;

   // Next-state logic and next values for the registered outputs.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (ifc.start) begin
               rem_d   = amt_clamped;
               op_d    = OP_SAVE;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Fin may still be high from the previous op; ignore it for HOLD cycles.
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + HCW'(1);
            end
         end
         S_WAIT: begin
            if (fin_sync) begin
               cnt_d   = '0;
               state_d = S_LOW;
            end else if (timed_out) begin
               state_d = S_ERR;
            end
         end
         S_LOW: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               rem_d = rem_dec;
               if (rem_dec == '0) begin
                  state_d = S_DONE;
               end else begin
                  op_d    = OP_SHIFT;
                  state_d = S_REQ;
               end
            end else begin
               cnt_d = cnt_q + HCW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      save_req_d  = ((state_d == S_REQ) || (state_d == S_WAIT)) && (op_d == OP_SAVE);
      right_req_d = ((state_d == S_REQ) || (state_d == S_WAIT)) && (op_d == OP_SHIFT);
      busy_d      = (state_d == S_REQ) || (state_d == S_WAIT) ||
                    (state_d == S_LOW) || (state_d == S_DONE);
      done_d      = (state_d == S_DONE);
   end

`ifdef SHIFT_SEQ_TIMEOUT_EN
   // WAIT-cycle counter, restarted whenever a new request phase begins.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == S_WAIT) begin
         to_cnt_d = to_cnt_q + TOW'(1);
      end else if (state_d == S_REQ) begin
         to_cnt_d = '0;
      end
      err_d = (state_d == S_ERR);
   end

   // Timeout counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end
`endif

   // State, counters, fin synchronisers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_SAVE;
         rem_q        <= '0;
         cnt_q        <= '0;
         save_sync_q  <= '0;
         right_sync_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         save_req_q   <= 1'b0;
         right_req_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         save_sync_q  <= {save_sync_q[0], ifc.saveFin};
         right_sync_q <= {right_sync_q[0], ifc.rightFin};
         busy_q       <= busy_d;
         done_q       <= done_d;
         save_req_q   <= save_req_d;
         right_req_q  <= right_req_d;
      end
   end
endmodule

// File: tb/tb_shift_sequencer.sv
`timescale 1ns/1ps
// tb_shift_sequencer: drives sequences against a behavioural async shift register.
// Latency: measured from the cycle start is presented to the cycle done is seen.
// Backpressure: the register model delays fin by a programmable number of cycles.
module tb_shift_sequencer;
   localparam int WIDTH   = 32;
   localparam int SHW     = 6;
   localparam int HOLD    = 4;
   localparam int TIMEOUT = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   shift_sequencer_if #(.SHW(SHW)) ifc ();

   shift_sequencer #(
      .Width(WIDTH), .SHW(SHW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ifc(ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural shift register: fin drops when req rises, returns fin_dly cycles later.
   logic [31:0] reg_in      = '0;
   logic [31:0] reg_out     = '0;
   int          fin_dly     = 1;
   bit          right_never = 1'b0;
   logic        save_fin_m  = 1'b1;
   logic        right_fin_m = 1'b1;
   logic        save_prev   = 1'b0;
   logic        right_prev  = 1'b0;
   int          save_cnt    = 0;
   int          right_cnt   = 0;

   assign ifc.saveFin  = save_fin_m;
   assign ifc.rightFin = right_fin_m;

   always @(posedge clk) begin
      save_prev  <= ifc.saveReq;
      right_prev <= ifc.rightReq;
      if (ifc.saveReq && !save_prev) begin
         save_fin_m <= 1'b0;
         save_cnt   <= fin_dly;
      end else if (save_cnt > 0) begin
         save_cnt <= save_cnt - 1;
         if (save_cnt == 1) begin
            save_fin_m <= 1'b1;
            reg_out    <= reg_in;
         end
      end
      if (ifc.rightReq && !right_prev) begin
         right_fin_m <= 1'b0;
         right_cnt   <= fin_dly;
      end else if (right_cnt > 0) begin
         right_cnt <= right_cnt - 1;
         if (right_cnt == 1 && !right_never) begin
            right_fin_m <= 1'b1;
            reg_out     <= reg_out >> 1;
         end
      end
   end

   // Protocol monitor: pulse counts, overlap and req-low gap violations.
   int   save_pulses = 0, right_pulses = 0, overlap = 0, gap_viol = 0;
   int   s_low = 100, r_low = 100;
   logic mon_s = 1'b0, mon_r = 1'b0;

   always @(negedge clk) begin
      mon_s <= ifc.saveReq;
      mon_r <= ifc.rightReq;
      if (ifc.saveReq && ifc.rightReq) overlap <= overlap + 1;
      if (ifc.saveReq && !mon_s) begin
         save_pulses <= save_pulses + 1;
         if (s_low < HOLD) gap_viol <= gap_viol + 1;
      end
      if (ifc.rightReq && !mon_r) begin
         right_pulses <= right_pulses + 1;
         if (r_low < HOLD) gap_viol <= gap_viol + 1;
      end
      s_low <= ifc.saveReq  ? 0 : s_low + 1;
      r_low <= ifc.rightReq ? 0 : r_low + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [SHW-1:0] amt;
      logic [31:0]    din;
      int             dly;
      int             lat;
      int             saves;
      int             rights;
      logic [31:0]    dout;
   } vec_t;

   vec_t vecs[5];
   vec_t sb[$];

   function automatic int clamp_n(input int n);
      return (n > WIDTH) ? WIDTH : n;
   endfunction

   // Latency with a prompt register: one cycle to accept, 2*HOLD+1 per op.
   function automatic int fast_lat(input int n);
      return 1 + (clamp_n(n) + 1) * (2 * HOLD + 1);
   endfunction

   function automatic vec_t mk(input int n, input logic [31:0] din, input int dly, input int lat);
      vec_t v;
      v.amt    = SHW'(n);
      v.din    = din;
      v.dly    = dly;
      v.lat    = lat;
      v.saves  = 1;
      v.rights = clamp_n(n);
      v.dout   = din >> clamp_n(n);
      return v;
   endfunction

   // One full sequence: drive start, queue the expectation, compare when done appears.
   task automatic run_seq(input vec_t v, input bit poke_busy);
      int   t0, base_s, base_r;
      vec_t e;
      @(negedge clk);
      reg_in       = v.din;
      fin_dly      = v.dly;
      base_s       = save_pulses;
      base_r       = right_pulses;
      ifc.shiftAmt = v.amt;
      ifc.start    = 1'b1;
      t0           = cyc;
      sb.push_back(v);
      @(negedge clk);
      ifc.start = 1'b0;
      check("busy_after_start", 32'(ifc.busy), 32'd1);
      check("err_low_running", 32'(ifc.err), 32'd0);
      while (!ifc.done && (cyc - t0) < v.lat + 100) begin
         @(negedge clk);
         if (poke_busy) begin
            ifc.start    = ((cyc - t0) == 30);
            ifc.shiftAmt = SHW'(5);
         end
      end
      ifc.start = 1'b0;
      e = sb.pop_front();
      if (!ifc.done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", v.lat + 100, e.lat);
      end else begin
         check("latency", 32'(cyc - t0), 32'(e.lat));
         check("save_pulses", 32'(save_pulses - base_s), 32'(e.saves));
         check("right_pulses", 32'(right_pulses - base_r), 32'(e.rights));
         check("reg_out", reg_out, e.dout);
         check("busy_in_done", 32'(ifc.busy), 32'd1);
         @(negedge clk);
         check("done_one_cycle", 32'(ifc.done), 32'd0);
         check("busy_after_done", 32'(ifc.busy), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int   base_r, r_rise, err_at;
      bit   hit, seen_done;
      vec_t v;

      vecs[0] = mk(3,  32'hF0F0_1234, 1, fast_lat(3));   // 37
      vecs[1] = mk(0,  32'hDEAD_BEEF, 1, fast_lat(0));   // 10
      vecs[2] = mk(40, 32'hFFFF_FFFF, 1, fast_lat(40));  // clamped to 32 shifts
      // fin 20 cycles late: req rises at E, fin at E+21, synced at E+23, LOW from E+24, op = 28.
      vecs[3] = mk(2,  32'h8000_0001, 20, 1 + 3 * 28);
      vecs[4] = mk(1,  32'h0000_0003, 1, fast_lat(1));

      ifc.start    = 1'b0;
      ifc.shiftAmt = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_done", 32'(ifc.done), 32'd0);
      check("rst_err", 32'(ifc.err), 32'd0);
      check("rst_saveReq", 32'(ifc.saveReq), 32'd0);
      check("rst_rightReq", 32'(ifc.rightReq), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_seq(vecs[i], (i == 3));
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of the second shift request, with start asserted at the same edge.
      @(negedge clk);
      reg_in       = 32'h1234_5678;
      fin_dly      = 1;
      base_r       = right_pulses;
      ifc.shiftAmt = SHW'(3);
      ifc.start    = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         hit = (right_pulses - base_r == 2) && ifc.rightReq;
      end
      check("second_right_reached", 32'(hit), 32'd1);
      rst_n     = 1'b0;
      ifc.start = 1'b1;
      @(negedge clk);
      check("midrst_saveReq", 32'(ifc.saveReq), 32'd0);
      check("midrst_rightReq", 32'(ifc.rightReq), 32'd0);
      check("midrst_busy", 32'(ifc.busy), 32'd0);
      check("midrst_done", 32'(ifc.done), 32'd0);
      ifc.start = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("midrst_idle", 32'(ifc.busy), 32'd0);
      repeat (HOLD + 2) @(negedge clk);
      run_seq(vecs[0], 1'b0);
      repeat (2) @(negedge clk);

`ifdef SHIFT_SEQ_TIMEOUT_EN
      // rightFin never returns: err after TIMEOUT cycles in WAIT, no done.
      right_never  = 1'b1;
      fin_dly      = 1;
      reg_in       = 32'h0000_00F0;
      ifc.shiftAmt = SHW'(2);
      ifc.start    = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      r_rise    = -1;
      err_at    = -1;
      seen_done = 1'b0;
      for (int n = 0; n < 300 && err_at < 0; n++) begin
         @(negedge clk);
         if (ifc.rightReq && r_rise < 0) r_rise = cyc;
         if (ifc.done) seen_done = 1'b1;
         if (ifc.err) err_at = cyc;
      end
      check("to_err_set", 32'(ifc.err), 32'd1);
      check("to_err_delay", 32'(err_at - r_rise), 32'(HOLD + TIMEOUT));
      check("to_no_done", 32'(seen_done), 32'd0);
      check("to_busy", 32'(ifc.busy), 32'd0);
      check("to_rightReq", 32'(ifc.rightReq), 32'd0);
      repeat (3) @(negedge clk);
      check("to_err_sticky", 32'(ifc.err), 32'd1);
      right_never = 1'b0;
      v = mk(0, 32'h0BAD_F00D, 1, fast_lat(0));
      run_seq(v, 1'b0);
`else
      repeat (2) @(negedge clk);
`endif

      check("req_overlap", 32'(overlap), 32'd0);
      check("req_low_gap", 32'(gap_viol), 32'd0);
      check("err_final", 32'(ifc.err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
